// File: rtl/lif_sched_pkg.sv
// Shared types and default sizing for the LIF timestep scheduler.
package lif_sched_pkg;

    localparam int LIF_N_PRE  = 256;
    localparam int LIF_N_POST = 256;
    localparam int LIF_CHUNK  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_ACC,
        ST_FIRE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lif_sched_prienc.sv
// Lowest-set-bit priority encoder used to pick the next spiking presynaptic neuron.
module lif_sched_prienc #(
    parameter int W  = 16,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/lif_step_scheduler.sv
// LIF timestep scheduler: loads an input spike frame in chunks, issues one
// accumulate command per (spiking pre, post) pair, then one fire command per
// post neuron, and pulses done.
// Optional feature macro: LIF_SCHED_PERF_EN adds busy-cycle and spike counters.
module lif_step_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_PRE  = LIF_N_PRE,
    parameter int N_POST = LIF_N_POST,
    parameter int CHUNK  = LIF_CHUNK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      in_req_i,
    input  logic [CHUNK-1:0]          in_rdata_i,
    output logic                      in_ack_o,
    input  logic                      dp_rdy_i,
    output logic                      acc_en_o,
    output logic                      fire_en_o,
    output logic [$clog2(N_PRE)-1:0]  pre_idx_o,
    output logic [$clog2(N_POST)-1:0] post_idx_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef LIF_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_cycles_o,
    output logic [$clog2(N_PRE):0]    perf_spikes_o
`endif
);

    localparam int NCHUNK = N_PRE / CHUNK;
    localparam int PRW    = $clog2(N_PRE);
    localparam int POW    = $clog2(N_POST);
    localparam int CCW    = $clog2(NCHUNK + 1);

    state_t           state;
    logic [N_PRE-1:0] bitmap;
    logic [CCW-1:0]   chunk_cnt;
    logic             enc_found;
    logic [PRW-1:0]   enc_idx;
    logic             post_last;

    lif_sched_prienc #(
        .W  (N_PRE),
        .IW (PRW)
    ) u_prienc (
        .vec   (bitmap),
        .found (enc_found),
        .index (enc_idx)
    );

    assign post_last = (post_idx_o == POW'(N_POST - 1));

    // Commands follow the datapath ready directly and only in their own state.
    assign acc_en_o  = (state == ST_ACC)  & dp_rdy_i;
    assign fire_en_o = (state == ST_FIRE) & dp_rdy_i;

    // Main control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bitmap     <= '0;
            chunk_cnt  <= '0;
            pre_idx_o  <= '0;
            post_idx_o <= '0;
            in_ack_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        bitmap    <= '0;
                        chunk_cnt <= '0;
                        busy_o    <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // The ack cycle never captures, so a held request needs
                    // an ack-low cycle before the next chunk is taken.
                    if (in_ack_o) begin
                        in_ack_o <= 1'b0;
                        if (chunk_cnt == CCW'(NCHUNK)) begin
                            state <= ST_SCAN;
                        end
                    end else if (in_req_i) begin
                        for (int c = 0; c < NCHUNK; c++) begin
                            if (chunk_cnt == CCW'(c)) begin
                                bitmap[c*CHUNK +: CHUNK] <= in_rdata_i;
                            end
                        end
                        in_ack_o  <= 1'b1;
                        chunk_cnt <= chunk_cnt + CCW'(1);
                    end
                end
                ST_SCAN: begin
                    post_idx_o <= '0;
                    if (enc_found) begin
                        pre_idx_o <= enc_idx;
                        state     <= ST_ACC;
                    end else begin
                        state <= ST_FIRE;
                    end
                end
                ST_ACC: begin
                    if (dp_rdy_i) begin
                        if (post_last) begin
                            bitmap[pre_idx_o] <= 1'b0;
                            post_idx_o        <= '0;
                            state             <= ST_SCAN;
                        end else begin
                            post_idx_o <= post_idx_o + POW'(1);
                        end
                    end
                end
                ST_FIRE: begin
                    if (dp_rdy_i) begin
                        if (post_last) begin
                            post_idx_o <= '0;
                            done_o     <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            post_idx_o <= post_idx_o + POW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LIF_SCHED_PERF_EN
    // Per-timestep counters: cleared on start, frozen once back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_o <= '0;
            perf_spikes_o <= '0;
        end else if (state == ST_IDLE) begin
            if (start_i) begin
                perf_cycles_o <= '0;
                perf_spikes_o <= '0;
            end
        end else begin
            perf_cycles_o <= perf_cycles_o + 32'd1;
            if (state == ST_SCAN && enc_found) begin
                perf_spikes_o <= perf_spikes_o + (PRW+1)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler (N_PRE=256, N_POST=4, CHUNK=16).
module tb_lif_step_scheduler;

    localparam int N_PRE  = 256;
    localparam int N_POST = 4;
    localparam int CHUNK  = 16;
    localparam int NCH    = N_PRE / CHUNK;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              in_req_i = 1'b0;
    logic [CHUNK-1:0]  in_rdata_i = '0;
    logic              in_ack_o;
    logic              dp_rdy_i = 1'b1;
    logic              acc_en_o;
    logic              fire_en_o;
    logic [7:0]        pre_idx_o;
    logic [1:0]        post_idx_o;
    logic              busy_o;
    logic              done_o;
`ifdef LIF_SCHED_PERF_EN
    logic [31:0]       perf_cycles_o;
    logic [8:0]        perf_spikes_o;
`endif

    lif_step_scheduler #(
        .N_PRE  (N_PRE),
        .N_POST (N_POST),
        .CHUNK  (CHUNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .in_req_i   (in_req_i),
        .in_rdata_i (in_rdata_i),
        .in_ack_o   (in_ack_o),
        .dp_rdy_i   (dp_rdy_i),
        .acc_en_o   (acc_en_o),
        .fire_en_o  (fire_en_o),
        .pre_idx_o  (pre_idx_o),
        .post_idx_o (post_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef LIF_SCHED_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o),
        .perf_spikes_o (perf_spikes_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fire;
        int   pre;
        int   post;
    } cmd_t;

    typedef struct {
        logic [N_PRE-1:0] frame;
        bit               toggle;
        bit               garb;
        int               exp_cyc;
    } vec_t;

    cmd_t exp_q[$];
    vec_t vt[5];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int last_ack_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int pops = 0;
    bit rdy_toggle = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compares every issued command against the scoreboard.
    initial begin
        cmd_t e;
        logic prev_ack;
        logic prev_done;
        prev_ack = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (acc_en_o && fire_en_o) begin
                checks++;
                failures++;
                $display("FAIL cmd_excl actual acc=1 fire=1 required one-hot");
            end else if (acc_en_o || fire_en_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_cmd actual fire=%0d pre=%0d post=%0d required no command",
                             fire_en_o, pre_idx_o, post_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    if (fire_en_o != e.fire || int'(post_idx_o) != e.post ||
                        (!e.fire && int'(pre_idx_o) != e.pre)) begin
                        failures++;
                        $display("FAIL cmd_seq actual fire=%0d pre=%0d post=%0d required fire=%0d pre=%0d post=%0d",
                                 fire_en_o, pre_idx_o, post_idx_o, e.fire, e.pre, e.post);
                    end
                end
            end
            if (in_ack_o) begin
                chk("ack_pulse_width", int'(prev_ack), 0);
                ack_cnt++;
                last_ack_cyc = cyc;
            end
            if (done_o) begin
                chk("done_pulse_width", int'(prev_done), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_ack = in_ack_o;
            prev_done = done_o;
        end
    end

    // Datapath ready: steady high, or alternating when requested.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dp_rdy_i = rdy_toggle ? ~dp_rdy_i : 1'b1;
        end
    end

    task automatic push_expect(input logic [N_PRE-1:0] f);
        for (int i = 0; i < N_PRE; i++)
            if (f[i])
                for (int p = 0; p < N_POST; p++) exp_q.push_back('{1'b0, i, p});
        for (int p = 0; p < N_POST; p++) exp_q.push_back('{1'b1, 0, p});
    endtask

    task automatic start_load(input vec_t v);
        bit got;
        rdy_toggle = v.toggle;
        push_expect(v.frame);
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            in_req_i = 1'b1;
            in_rdata_i = v.frame[c*CHUNK +: CHUNK];
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(posedge clk); #1;
                if (in_ack_o) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("ack_timeout", 0, 1);
                in_req_i = 1'b0;
                return;
            end
            if (v.garb) begin
                // Keep the request up through the ack cycle with junk data.
                in_rdata_i = ~v.frame[c*CHUNK +: CHUNK];
                @(posedge clk); #1;
            end
        end
        in_req_i = 1'b0;
    endtask

    task automatic finish_frame(input vec_t v, input int ack0, input int done0);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            if (done_cnt > done0) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(got), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("ack_count", ack_cnt - ack0, NCH);
        chk("done_count", done_cnt - done0, 1);
        chk("queue_empty", exp_q.size(), 0);
        if (v.exp_cyc >= 0) chk("latency", done_cyc - last_ack_cyc, v.exp_cyc);
        chk("idle_busy", int'(busy_o), 0);
        exp_q.delete();
        rdy_toggle = 1'b0;
    endtask

    initial begin
        int a0;
        int d0;
        int p0;
        bit got;

        // Stimulus table: frame, ready toggling, junk-on-ack, expected latency.
        for (int i = 0; i < 5; i++) begin
            vt[i].frame = '0;
            vt[i].toggle = 1'b0;
            vt[i].garb = 1'b0;
        end
        vt[0].frame[5] = 1'b1;                         vt[0].exp_cyc = 11;
                                                       vt[1].exp_cyc = N_POST + 2;
        vt[2].frame[0] = 1'b1; vt[2].frame[17] = 1'b1;
        vt[2].frame[255] = 1'b1;                       vt[2].exp_cyc = 3*(N_POST+1) + N_POST + 2;
        vt[3].frame[3] = 1'b1; vt[3].frame[100] = 1'b1;
        vt[3].toggle = 1'b1;                           vt[3].exp_cyc = -1;
        vt[4].frame[1] = 1'b1; vt[4].frame[20] = 1'b1;
        vt[4].garb = 1'b1;                             vt[4].exp_cyc = 2*(N_POST+1) + N_POST + 2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ack", int'(in_ack_o), 0);
        chk("rst_acc", int'(acc_en_o), 0);
        chk("rst_fire", int'(fire_en_o), 0);
        chk("rst_post", int'(post_idx_o), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", int'(busy_o), 0);

        for (int i = 0; i < 5; i++) begin
            a0 = ack_cnt;
            d0 = done_cnt;
            start_load(vt[i]);
            finish_frame(vt[i], a0, d0);
        end

        // Reset in the middle of an ACC burst.
        p0 = pops;
        start_load(vt[0]);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pops >= p0 + 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach_acc", int'(got), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midacc_acc", int'(acc_en_o), 0);
        chk("midacc_fire", int'(fire_en_o), 0);
        chk("midacc_busy", int'(busy_o), 0);
        chk("midacc_pre", int'(pre_idx_o), 0);
        chk("midacc_post", int'(post_idx_o), 0);
        chk("midacc_done", int'(done_o), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(busy_o), 0);

        a0 = ack_cnt;
        d0 = done_cnt;
        start_load(vt[2]);
        finish_frame(vt[2], a0, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lif_step_scheduler.md
LIF_STEP_SCHEDULER -- requirements
Module: lif_step_scheduler

Interface
REQ-001 Parameter N_PRE, default 256: presynaptic neuron count, a multiple of CHUNK.
REQ-002 Parameter N_POST, default 256: postsynaptic neuron count.
REQ-003 Parameter CHUNK, default 16: input spike bits per handshake.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  begin one timestep; sampled only in IDLE.
REQ-007 in_req_i  input  1  input spike chunk valid.
REQ-008 in_rdata_i  input  CHUNK  spike chunk; bit j is presynaptic neuron chunk_idx*CHUNK+j.
REQ-009 in_ack_o  output  1  chunk-captured pulse.
REQ-010 dp_rdy_i  input  1  datapath can accept an acc/fire command this cycle.
REQ-011 acc_en_o  output  1  command: membrane[post_idx_o] += weight[pre_idx_o][post_idx_o].
REQ-012 fire_en_o  output  1  command: leak, threshold and reset of membrane[post_idx_o]; emit spike.
REQ-013 pre_idx_o  output  clog2(N_PRE)  presynaptic index.
REQ-014 post_idx_o  output  clog2(N_POST)  postsynaptic index.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 done_o  output  1  one-cycle timestep-complete pulse.

Function
REQ-017 States are IDLE, LOAD, SCAN, ACC, FIRE and DONE.
REQ-018 IDLE: on start_i=1, clear the spike bitmap and the chunk counter, then go to LOAD; start_i is ignored in all other states.
REQ-019 LOAD: when in_req_i=1 and in_ack_o=0, capture in_rdata_i into the bitmap at the current chunk slot, raise in_ack_o for exactly the next cycle, and increment the chunk counter.
REQ-020 A request held high across the ack cycle is not recaptured; the next capture requires the ack-low cycle that follows.
REQ-021 After the capture of chunk N_PRE/CHUNK-1, go to SCAN on the cycle after the ack.
REQ-022 SCAN: in one cycle, select the lowest set bitmap index. If one exists, latch it into pre_idx_o, zero post_idx_o and go to ACC. If none exists, zero post_idx_o and go to FIRE.
REQ-023 ACC: acc_en_o equals dp_rdy_i. On each cycle with dp_rdy_i=1, post_idx_o advances. On the cycle that issues post index N_POST-1, clear the bitmap bit at pre_idx_o and return to SCAN.
REQ-024 FIRE: fire_en_o equals dp_rdy_i and post_idx_o advances on each cycle with dp_rdy_i=1. After index N_POST-1 is issued, go to DONE.
REQ-025 DONE: done_o=1 for one cycle, then go to IDLE.
REQ-026 With dp_rdy_i held high and k input spikes, the cycles from LOAD exit to done_o are k*(N_POST+1)+1+N_POST+1.
REQ-027 An all-zero frame goes straight from SCAN to FIRE; FIRE always runs.
REQ-028 Index counters wrap only through an explicit reload, never through arithmetic overflow.
REQ-029 acc_en_o and fire_en_o are never high together, and each is low outside its own state.

Reset
REQ-030 When rst=0: state goes to IDLE; bitmap, counters, pre_idx_o and post_idx_o go to 0; in_ack_o, acc_en_o, fire_en_o, busy_o and done_o go to 0. This applies immediately, including mid-LOAD, mid-ACC and mid-FIRE.
REQ-031 After rst deasserts, no command is issued until a new start_i.

Configuration
REQ-032 LIF_SCHED_PERF_EN defined: add outputs perf_cycles_o (32 bits) and perf_spikes_o (clog2(N_PRE)+1 bits).
- perf_cycles_o counts busy cycles of the last timestep.
- perf_spikes_o counts ACC entries of the last timestep.
- Both are cleared on start and hold their value after DONE.
REQ-033 LIF_SCHED_PERF_EN undefined: neither the ports nor the counters exist; all other behaviour is identical.

Structure
REQ-034 Package lif_sched_pkg holds the state enum and the default N_PRE, N_POST and CHUNK constants.
REQ-035 Sub-module lif_sched_prienc is a parameterised lowest-set-bit encoder with outputs found and index, used by SCAN.

Verification
REQ-036 The bench shall cover the following directed scenarios:
- One spike, pre 5, N_POST=4, dp_rdy_i=1 -> 4 acc_en_o pulses at pre=5, post 0..3 -> 4 fire_en_o pulses at post 0..3 -> done_o; 11 cycles from LOAD exit.
- All-zero frame -> zero acc_en_o pulses; FIRE follows SCAN immediately; done_o after N_POST+2 cycles.
- Spikes at pre 0, 17 and 255 -> ACC bursts in order 0, 17, 255; bitmap empty at FIRE.
- dp_rdy_i toggling 1/0 during ACC -> post_idx_o holds on low cycles; no index skipped or repeated.
- in_req_i held high for 3 cycles -> exactly one capture and one ack pulse per chunk.
- rst asserted mid-ACC -> all outputs 0 at once; a fresh start_i then completes a correct timestep.
